// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability-counter FSM producing a clean level, press/release strobes and a press count.
// Optional auto-repeat of press strobes while held: define BTN_AUTOREPEAT_EN.
module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY  = 256,
    parameter int unsigned REPEAT_PERIOD = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned    CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("button_debouncer: parameter out of legal range");
    end

    logic [1:0]    r_state;
    logic          r_s1;
    logic          r_s2;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic [7:0]    r_count;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned     RMAX       = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned     RPW        = $clog2(RMAX + 1);
    localparam logic [RPW-1:0]  REP_DELAY  = RPW'(REPEAT_DELAY - 1);
    localparam logic [RPW-1:0]  REP_PERIOD = RPW'(REPEAT_PERIOD - 1);

    logic [RPW-1:0] r_rep;
    logic           r_rep_first;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_count   <= '0;
`ifdef BTN_AUTOREPEAT_EN
            r_rep       <= '0;
            r_rep_first <= 1'b1;
`endif
        end else begin
            r_s1      <= btn_in;
            r_s2      <= r_s1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            // Held at its start value outside PRESSED, so leaving PRESSED always clears it.
            if (r_state != ST_PRESSED) begin
                r_rep       <= '0;
                r_rep_first <= 1'b1;
            end
`endif
            case (r_state)
                ST_IDLE: begin
                    if (r_s2) begin
                        r_state <= ST_PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!r_s2) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                        r_count <= r_count + 8'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!r_s2) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_cnt   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                        r_rep       <= '0;
                        r_rep_first <= 1'b1;
                    end else if (r_rep == (r_rep_first ? REP_DELAY : REP_PERIOD)) begin
                        r_rep       <= '0;
                        r_rep_first <= 1'b0;
                        r_press     <= 1'b1;
                        r_count     <= r_count + 8'd1;
                    end else begin
                        r_rep <= r_rep + 1'b1;
`endif
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (r_s2) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign press_count   = r_count;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: reset, latency, bounce, glitch, wrap, async reset, optional auto-repeat.
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] press_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_press  = 0;
    int n_release = 0;
    int last_press = -1000;
    logic prev_press = 1'b0;
    logic prev_release = 1'b0;
    int press_q[$];

    button_debouncer #(.STABLE_CYCLES(16), .REPEAT_DELAY(256), .REPEAT_PERIOD(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Strobe monitor: width, exclusivity and press-to-press spacing.
    always @(negedge clk) begin
        if (press_pulse || release_pulse)
            check("exclusive", int'(press_pulse && release_pulse), 0);
        if (press_pulse) begin
            check("press_width", int'(prev_press), 0);
            check("press_spacing", int'((cyc - last_press) >= 32), 1);
            n_press++;
            last_press = cyc;
            press_q.push_back(cyc);
        end
        if (release_pulse) begin
            check("release_width", int'(prev_release), 0);
            n_release++;
        end
        prev_press   = press_pulse;
        prev_release = release_pulse;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic click(input int hi, input int lo);
        btn_in = 1'b1;
        cycles(hi);
        btn_in = 1'b0;
        cycles(lo);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        btn_in = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
    endtask

    int k;
    int p0, r0;

    initial begin
        // Reset with button held high
        rst_n  = 1'b0;
        btn_in = 1'b1;
        cycles(10);
        check("rst_level", btn_level, 0);
        check("rst_press", press_pulse, 0);
        check("rst_release", release_pulse, 0);
        check("rst_count", press_count, 0);

        press_q.delete();
        k = cyc + 1;
        rst_n = 1'b1;
        cycles(25);
        check("lat_npress", n_press, 1);
        check("lat_qsize", press_q.size(), 1);
        if (press_q.size() > 0) check("lat_cycle", press_q[0] - k, 18);
        check("lat_count", press_count, 1);
        check("lat_level", btn_level, 1);
        btn_in = 1'b0;
        cycles(25);
        check("rel_nrelease", n_release, 1);
        check("rel_level", btn_level, 0);

        // Bounce on press and release
        p0 = n_press; r0 = n_release;
        for (int i = 0; i < 7; i++) begin btn_in = ~i[0]; cycles(1); end
        btn_in = 1'b1;
        cycles(200);
        check("bounce_level_hi", btn_level, 1);
        for (int i = 0; i < 7; i++) begin btn_in = i[0]; cycles(1); end
        btn_in = 1'b0;
        cycles(100);
        check("bounce_press", n_press - p0, 1);
        check("bounce_release", n_release - r0, 1);
        check("bounce_count", press_count, 2);
        check("bounce_level_lo", btn_level, 0);

        // Short glitches
        p0 = n_press;
        click(10, 30);
        check("glitch10_press", n_press - p0, 0);
        check("glitch10_level", btn_level, 0);
        click(15, 30);
        check("glitch15_press", n_press - p0, 0);
        check("glitch_count", press_count, 2);
        click(25, 30);
        check("after_glitch_press", n_press - p0, 1);
        check("after_glitch_count", press_count, 3);

        // Wrap of press_count
        do_reset();
        check("wrap_start", press_count, 0);
        for (int i = 0; i < 255; i++) click(25, 25);
        check("wrap_255", press_count, 255);
        click(25, 25);
        check("wrap_0", press_count, 0);

        // Asynchronous reset during PRESS_WAIT and during PRESSED
        do_reset();
        p0 = n_press; r0 = n_release;
        btn_in = 1'b1;
        cycles(10);
        #2 rst_n = 1'b0;
        #1 check("arst_wait_level", btn_level, 0);
        check("arst_wait_count", press_count, 0);
        btn_in = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(30);
        check("arst_wait_press", n_press - p0, 0);
        btn_in = 1'b1;
        cycles(40);
        check("arst_pressed_level", btn_level, 1);
        check("arst_pressed_count", press_count, 1);
        #2 rst_n = 1'b0;
        #1 check("arst_level", btn_level, 0);
        check("arst_count", press_count, 0);
        check("arst_pulse", press_pulse, 0);
        btn_in = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(40);
        check("arst_no_release", n_release - r0, 0);
        check("arst_level_after", btn_level, 0);

`ifdef BTN_AUTOREPEAT_EN
        // Auto-repeat while held
        do_reset();
        press_q.delete();
        p0 = n_press; r0 = n_release;
        k = cyc + 1;
        btn_in = 1'b1;
        cycles(518);
        btn_in = 1'b0;
        cycles(100);
        check("rep_npress", n_press - p0, 5);
        check("rep_count", press_count, 5);
        check("rep_release", n_release - r0, 1);
        check("rep_qsize", press_q.size(), 5);
        if (press_q.size() == 5) begin
            check("rep_off0", press_q[0] - k, 18);
            check("rep_off1", press_q[1] - press_q[0], 256);
            check("rep_off2", press_q[2] - press_q[0], 320);
            check("rep_off3", press_q[3] - press_q[0], 384);
            check("rep_off4", press_q[4] - press_q[0], 448);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
